bus_master_serializer: RTL and testbench
========================================

BUS_MASTER_SERIALIZER -- requirements
Module: bus_master_serializer

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, address width in bits.
REQ-002 SHALL have parameter DATA_W, default 8, data width in bits.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 255, cycles to wait for a target before flagging an error.
REQ-004 SHALL have port clk  input  1  clock; all logic on the rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid  input  1  master request strobe.
REQ-007 SHALL have port req_ready  output  1  block can accept a request.
REQ-008 SHALL have port req_write  input  1  1 = write, 0 = read.
REQ-009 SHALL have port req_addr  input  ADDR_W  target address.
REQ-010 SHALL have port req_wdata  input  DATA_W  write data.
REQ-011 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have port resp_rdata  output  DATA_W  read data; valid only while resp_valid is high.
REQ-013 SHALL have port resp_err  output  1  timeout error; valid only while resp_valid is high.
REQ-014 SHALL have port bus_data_out  output  1  serial bit to the bus and address decoder.
REQ-015 SHALL have port bus_data_out_valid  output  1  bus_data_out carries a valid bit.
REQ-016 SHALL have port bus_mode  output  1  0 = address phase, 1 = data phase.
REQ-017 SHALL have port bus_rdata_in  input  1  serial read bit from the selected target.
REQ-018 SHALL have port bus_rdata_in_valid  input  1  bus_rdata_in carries a valid bit.
REQ-019 SHALL have port target_ack  input  1  selected target has accepted the write data.

Function
REQ-020 SHALL implement the states IDLE, ADDR, GAP, WDATA, RDATA, WAIT_ACK and RESP.
REQ-021 SHALL drive req_ready high only in IDLE, and SHALL accept a request on req_valid && req_ready by latching addr, wdata and write, then moving to ADDR.
REQ-022 SHALL, in ADDR, shift out req_addr LSB-first, one bit per cycle for ADDR_W cycles, with bus_mode=0 and bus_data_out_valid=1; bit 0 appears in the cycle after acceptance.
REQ-023 SHALL, after the last address bit, spend exactly one GAP cycle with bus_data_out_valid=0 and bus_mode=1, so the decoder can load its select.
REQ-024 SHALL, for a write, go GAP->WDATA and shift req_wdata out LSB-first for DATA_W cycles with bus_mode=1 and bus_data_out_valid=1, then go to WAIT_ACK.
REQ-025 SHALL, for a read, go GAP->RDATA and shift in bus_rdata_in LSB-first on each cycle bus_rdata_in_valid is high, with gaps in valid allowed; after DATA_W bits it goes to RESP.
REQ-026 SHALL, in WAIT_ACK, go to RESP in the cycle after target_ack is sampled high.
REQ-027 SHALL, in RESP, pulse resp_valid for one cycle, then return to IDLE; there is no response backpressure.
REQ-028 SHALL hold bus_data_out and bus_data_out_valid at 0 in IDLE, WAIT_ACK, RDATA and RESP.
REQ-029 SHALL hold bus_mode at 0 in IDLE and ADDR, and at 1 in all other states.
REQ-030 SHALL ignore bus_rdata_in_valid outside RDATA and target_ack outside WAIT_ACK.
REQ-031 SHALL use a single bit counter of $clog2(ADDR_W)+1 bits, cleared on every state entry.
REQ-032 SHALL drive resp_rdata as 0 for writes.

Reset
REQ-033 SHALL, while rst_n is low, force IDLE, with req_ready=1 and every other output, counter and latched field at 0.
REQ-034 SHALL, on reset asserted mid-transfer, abandon the transfer immediately with no response pulse; the next request restarts from address bit 0.

Configuration
REQ-035 SHALL, with BUS_MASTER_TIMEOUT_EN defined, count cycles in WAIT_ACK and RDATA and, on reaching TIMEOUT_CYC, go to RESP with resp_err=1 and resp_rdata=0.
REQ-036 SHALL, with BUS_MASTER_TIMEOUT_EN defined, give target_ack or the final read bit priority over a timeout expiring in the same cycle (resp_err=0).
REQ-037 SHALL, without BUS_MASTER_TIMEOUT_EN, wait indefinitely, tie resp_err to 0 and omit the timeout counter.

Structure
REQ-038 SHALL take the state enum, the MODE_ADDR=0/MODE_DATA=1 constants and the default widths from shared package serial_bus_pkg.
REQ-039 SHALL place the timeout counter in sub-module bus_timeout_ctr (inputs clear and enable; output expired), instantiated only under BUS_MASTER_TIMEOUT_EN.

Verification
REQ-040 SHALL cover a write to 0x0123 with data 0xA5 and target_ack 3 cycles after WAIT_ACK entry -> 16 address bits LSB-first with mode 0, 1 gap cycle, data bits 1,0,1,0,0,1,0,1 with mode 1, then resp_valid with err=0 one cycle after ack.
REQ-041 SHALL cover a read of 0x4000 with the target returning 0x3C, bus_rdata_in_valid toggling every other cycle -> resp_rdata=0x3C, err=0.
REQ-042 SHALL cover, with BUS_MASTER_TIMEOUT_EN and TIMEOUT_CYC=20, a write to unmapped 0xC000 with no ack -> resp_err=1 exactly 20 cycles after WAIT_ACK entry.
REQ-043 SHALL cover req_valid held high throughout a transfer -> req_ready=0 until the transfer ends, and the second request is accepted in the first IDLE cycle after resp_valid.
REQ-044 SHALL cover rst_n pulsed during address bit 7 -> outputs 0 immediately, no resp_valid, and the next request serializes from bit 0.
REQ-045 SHALL cover target_ack arriving in the same cycle the timeout expires -> resp_valid with resp_err=0.

Source files
------------

// File: rtl/serial_bus_pkg.sv
// Shared state encoding, bus-mode constants and default widths for the serial bus master.
package serial_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        GAP,
        WDATA,
        RDATA,
        WAIT_ACK,
        RESP
    } state_t;

    localparam logic MODE_ADDR = 1'b0;
    localparam logic MODE_DATA = 1'b1;

    localparam int DEF_ADDR_W      = 16;
    localparam int DEF_DATA_W      = 8;
    localparam int DEF_TIMEOUT_CYC = 255;

endpackage

// File: rtl/bus_timeout_ctr.sv
// Cycle counter that flags expiry in the TIMEOUT_CYC-th enabled cycle after a clear.
module bus_timeout_ctr
    import serial_bus_pkg::*;
#(
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int              CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = enable && (cnt == LAST);

endmodule

// File: rtl/bus_master_serializer.sv
// Serializes address/write data onto a one-bit bus and collects serial read data.
// Optional target timeout is enabled by defining BUS_MASTER_TIMEOUT_EN.
module bus_master_serializer
    import serial_bus_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              bus_data_out,
    output logic              bus_data_out_valid,
    output logic              bus_mode,
    input  logic              bus_rdata_in,
    input  logic              bus_rdata_in_valid,
    input  logic              target_ack
);

    localparam int               CNT_W     = $clog2(ADDR_W) + 1;
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

    state_t            state;
    state_t            state_nx;
    logic [CNT_W-1:0]  bit_cnt;
    logic [ADDR_W-1:0] addr_sh;
    // Holds write data being shifted out, or read data being shifted in.
    logic [DATA_W-1:0] data_sh;
    logic              write_q;
    logic              rd_last;
    logic              tmo_expired;
    logic              err_flag;

    assign rd_last = (state == RDATA) && bus_rdata_in_valid && (bit_cnt == DATA_LAST);

`ifdef BUS_MASTER_TIMEOUT_EN
    logic err_q;
    logic timeout_hit;
    logic tmo_active;

    assign tmo_active  = (state == WAIT_ACK) || (state == RDATA);
    // A completing ack or final read bit wins over an expiry in the same cycle.
    assign timeout_hit = tmo_expired && !rd_last && !((state == WAIT_ACK) && target_ack);

    bus_timeout_ctr #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (!tmo_active),
        .enable (tmo_active),
        .expired(tmo_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (state == IDLE) begin
            err_q <= 1'b0;
        end else if (timeout_hit) begin
            err_q <= 1'b1;
        end
    end

    assign err_flag = err_q;
`else
    assign tmo_expired = 1'b0;
    assign err_flag    = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (req_valid) state_nx = ADDR;
            ADDR:     if (bit_cnt == ADDR_LAST) state_nx = GAP;
            GAP:      state_nx = write_q ? WDATA : RDATA;
            WDATA:    if (bit_cnt == DATA_LAST) state_nx = WAIT_ACK;
            RDATA:    if (rd_last || tmo_expired) state_nx = RESP;
            WAIT_ACK: if (target_ack || tmo_expired) state_nx = RESP;
            RESP:     state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            bit_cnt <= '0;
            addr_sh <= '0;
            data_sh <= '0;
            write_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (state_nx != state) begin
                bit_cnt <= '0;
            end else if ((state == ADDR) || (state == WDATA) ||
                         ((state == RDATA) && bus_rdata_in_valid)) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_sh <= req_addr;
                        data_sh <= req_wdata;
                        write_q <= req_write;
                    end
                end
                ADDR:  addr_sh <= addr_sh >> 1;
                WDATA: data_sh <= data_sh >> 1;
                RDATA: if (bus_rdata_in_valid) data_sh <= {bus_rdata_in, data_sh[DATA_W-1:1]};
                default: ;
            endcase
        end
    end

    assign req_ready          = (state == IDLE);
    assign bus_data_out_valid = (state == ADDR) || (state == WDATA);
    assign bus_data_out       = (state == ADDR)  ? addr_sh[0] :
                                (state == WDATA) ? data_sh[0] : 1'b0;
    assign bus_mode           = ((state == IDLE) || (state == ADDR)) ? MODE_ADDR : MODE_DATA;
    assign resp_valid         = (state == RESP);
    assign resp_err           = resp_valid && err_flag;
    assign resp_rdata         = (resp_valid && !write_q && !err_flag) ? data_sh : '0;

endmodule

// File: tb/tb_bus_master_serializer.sv
// Randomized scoreboard bench for bus_master_serializer; timeout cases need BUS_MASTER_TIMEOUT_EN.
module tb_bus_master_serializer;

    localparam int AW  = 16;
    localparam int DW  = 8;
    localparam int TMO = 20;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          resp_valid;
    logic [DW-1:0] resp_rdata;
    logic          resp_err;
    logic          bus_data_out;
    logic          bus_data_out_valid;
    logic          bus_mode;
    logic          bus_rdata_in = 1'b0;
    logic          bus_rdata_in_valid = 1'b0;
    logic          target_ack = 1'b0;

    bus_master_serializer #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid),
        .resp_rdata(resp_rdata),
        .resp_err(resp_err),
        .bus_data_out(bus_data_out),
        .bus_data_out_valid(bus_data_out_valid),
        .bus_mode(bus_mode),
        .bus_rdata_in(bus_rdata_in),
        .bus_rdata_in_valid(bus_rdata_in_valid),
        .target_ack(target_ack)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic b; logic m; } bit_t;
    typedef struct packed { logic [DW-1:0] rd; logic err; } resp_t;

    bit_t  exp_bits[$];
    resp_t exp_resp[$];
    int    n_checks = 0;
    int    n_pass = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    endfunction

    function automatic void fail_now(input string name);
        n_checks++;
        $display("FAIL %s: actual=event expected=none", name);
    endfunction

    // Monitor: every bus bit and every response is matched against the queued expectation.
    initial begin
        bit_t  eb;
        resp_t er;
        forever begin
            @(negedge clk);
            if (bus_data_out_valid) begin
                if (exp_bits.size() == 0) fail_now("unexpected_bus_bit");
                else begin
                    eb = exp_bits.pop_front();
                    check("bus_bit", 32'(bus_data_out), 32'(eb.b));
                    check("bus_mode", 32'(bus_mode), 32'(eb.m));
                end
            end
            if (resp_valid) begin
                if (exp_resp.size() == 0) fail_now("unexpected_resp");
                else begin
                    er = exp_resp.pop_front();
                    check("resp_rdata", 32'(resp_rdata), 32'(er.rd));
                    check("resp_err", 32'(resp_err), 32'(er.err));
                end
            end
        end
    end

    task automatic junk_inputs();
        bus_rdata_in_valid = 1'($urandom);
        bus_rdata_in       = 1'($urandom);
        target_ack         = 1'($urandom);
    endtask

    // One transaction; for reads d is the value the target returns. ack_dly<0 means never ack.
    task automatic txn(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input int ack_dly, input bit toggle, input bit hold);
        int   n;
        int   j;
        int   k;
        int   c;
        bit   done;
        logic e_err;
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            fail_now("req_ready_wait");
            return;
        end
        for (int i = 0; i < AW; i++) exp_bits.push_back('{a[i], 1'b0});
        if (wr) for (int i = 0; i < DW; i++) exp_bits.push_back('{d[i], 1'b1});
        e_err = 1'b0;
`ifdef BUS_MASTER_TIMEOUT_EN
        if (wr && (ack_dly < 0 || ack_dly >= TMO)) e_err = 1'b1;
`endif
        exp_resp.push_back('{(wr || e_err) ? '0 : d, e_err});
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        @(negedge clk);
        if (!hold) begin
            req_valid = 1'b0;
            req_addr  = AW'($urandom);
            req_wdata = DW'($urandom);
            req_write = 1'($urandom);
        end
        for (int i = 0; i < AW; i++) begin
            check("busy_ready", 32'(req_ready), 32'd0);
            junk_inputs();
            @(negedge clk);
        end
        check("gap_valid", 32'(bus_data_out_valid), 32'd0);
        check("gap_mode", 32'(bus_mode), 32'd1);
        check("gap_ready", 32'(req_ready), 32'd0);
        junk_inputs();
        @(negedge clk);
        if (wr) begin
            for (int i = 0; i < DW; i++) begin
                junk_inputs();
                @(negedge clk);
            end
            bus_rdata_in_valid = 1'b0;
            j = 0;
            done = 1'b0;
            while (!done) begin
                target_ack = (j == ack_dly);
                done = (j == ack_dly) || (j >= 400);
`ifdef BUS_MASTER_TIMEOUT_EN
                if (j == TMO - 1) done = 1'b1;
`endif
                @(negedge clk);
                j++;
                if (!done) check("wait_no_resp", 32'(resp_valid), 32'd0);
            end
            target_ack = 1'b0;
        end else begin
            target_ack = 1'b0;
            k = 0;
            c = 0;
            while (k < DW && c < 400) begin
                bus_rdata_in_valid = toggle ? c[0] : 1'b1;
                bus_rdata_in = bus_rdata_in_valid ? d[k] : 1'($urandom);
                if (bus_rdata_in_valid) k++;
                @(negedge clk);
                c++;
                if (k < DW) check("rd_no_resp", 32'(resp_valid), 32'd0);
            end
            bus_rdata_in_valid = 1'b0;
        end
        check("resp_timing", 32'(resp_valid), 32'd1);
        @(negedge clk);
        check("idle_ready", 32'(req_ready), 32'd1);
        check("idle_quiet", 32'({resp_valid, bus_data_out_valid, bus_mode}), 32'd0);
    endtask

    task automatic reset_mid_addr(input logic [AW-1:0] a);
        for (int i = 0; i < 8; i++) exp_bits.push_back('{a[i], 1'b0});
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = a;
        req_wdata = 8'h5A;
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 7; i++) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_outputs", 32'({bus_data_out, bus_data_out_valid, bus_mode, resp_valid, resp_err, resp_rdata}), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_bits_seen", 32'(exp_bits.size()), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1;
        check("reset_ready", 32'(req_ready), 32'd1);
        check("reset_outputs", 32'({bus_data_out, bus_data_out_valid, bus_mode, resp_valid, resp_err, resp_rdata}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        txn(1'b1, 16'h0123, 8'hA5, 3, 1'b0, 1'b0);
        txn(1'b0, 16'h4000, 8'h3C, 0, 1'b1, 1'b0);
        txn(1'b1, 16'hBEEF, 8'h81, 2, 1'b0, 1'b1);
        txn(1'b1, 16'hBEEF, 8'h81, 1, 1'b0, 1'b0);
        reset_mid_addr(16'hF0F0);
        txn(1'b1, 16'h1357, 8'h6E, 0, 1'b0, 1'b0);
`ifdef BUS_MASTER_TIMEOUT_EN
        txn(1'b1, 16'hC000, 8'h77, -1, 1'b0, 1'b0);
        txn(1'b1, 16'hC001, 8'h12, TMO - 1, 1'b0, 1'b0);
`endif
        for (int r = 0; r < 12; r++) begin
            txn(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom),
                int'($urandom_range(0, 8)), 1'($urandom_range(0, 1)), 1'b0);
        end
        repeat (3) @(negedge clk);
        check("bits_drained", 32'(exp_bits.size()), 32'd0);
        check("resp_drained", 32'(exp_resp.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
